// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - response checker for two-input gate stimulus runs
// Compares observed gate outputs with a golden truth table, counting passes/fails.
module gate_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             vec_c,
  output logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       gate_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             exp_c;
  logic             reserved_q;
  logic             mismatch;
  logic             accept;
  logic             last_vec;
  logic             launch;

  assign vec_ready  = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign launch     = start && (state == IDLE || state == DONE);
  assign accept     = vec_valid && (state == RUN);
  assign last_vec   = (acc_cnt == num_q - CNT_W'(1));
  assign reserved_q = (gate_q[2:1] == 2'b11);

  always_comb begin
    exp_c = 1'b0;
    case (gate_q)
      3'd0:    exp_c = vec_a | vec_b;
      3'd1:    exp_c = vec_a & vec_b;
      3'd2:    exp_c = vec_a ^ vec_b;
      3'd3:    exp_c = ~(vec_a | vec_b);
      3'd4:    exp_c = ~(vec_a & vec_b);
      3'd5:    exp_c = ~(vec_a ^ vec_b);
      default: exp_c = 1'b0;
    endcase
  end

  // Reserved gates have no golden value, so every vector is a mismatch.
  assign mismatch = reserved_q || (vec_c != exp_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = (num_vecs == '0) ? DONE : RUN;
      RUN:        if (vec_valid && last_vec) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q         <= '0;
      num_q          <= '0;
      acc_cnt        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (launch) begin
      gate_q         <= gate_sel;
      num_q          <= num_vecs;
      acc_cnt        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= (num_vecs == '0) && (gate_sel[2:1] != 2'b11);
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
      if (mismatch) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!first_fail_vld) begin
          first_fail_idx <= acc_cnt;
          first_fail_vld <= 1'b1;
        end
      end else if (pass_cnt != '1) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end
      // Verdict includes the vector accepted on the completing edge.
      if (last_vec) pass <= (fail_cnt == '0) && !mismatch && !reserved_q;
    end
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Sequential response checker for the logic-gates library: the receiving end of the two-input gate stimulus flow.
- A stimulus source presents (a, b, c) vectors, where c is the gate-under-test output; this block compares each c against the golden truth table of a selected gate.
- Counts passes and fails, and records the index of the first failing vector.
- Used in self-checking benches and in on-chip BIST wrappers around the gate modules.

Parameters:
- CNT_W, 8, width of the vector count, the pass/fail counters and the fail-index register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a run; honoured only in IDLE or DONE.
- gate_sel  input  3  gate to check: 0=OR, 1=AND, 2=XOR, 3=NOR, 4=NAND, 5=XNOR, 6/7 reserved.
- num_vecs  input  CNT_W  number of vectors in the run.
- vec_valid  input  1  source has a vector on vec_a/vec_b/vec_c.
- vec_a  input  1  gate input a.
- vec_b  input  1  gate input b.
- vec_c  input  1  observed gate output.
- vec_ready  output  1  checker accepts a vector this cycle.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  in DONE: fail_cnt==0 and gate_sel was not reserved.
- pass_cnt  output  CNT_W  matching vectors.
- fail_cnt  output  CNT_W  mismatching vectors.
- first_fail_idx  output  CNT_W  0-based index of the first mismatching vector.
- first_fail_vld  output  1  first_fail_idx holds a valid index.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; internal accept counter 0. Reset mid-run aborts the run immediately with no done.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Latch gate_sel and num_vecs.
  - Clear pass_cnt, fail_cnt, first_fail_idx, first_fail_vld, pass and the accept counter.
  - Next state is RUN, or DONE if num_vecs==0. In that case pass=1 for a valid gate_sel, pass=0 for a reserved one.
- RUN:
  - vec_ready=1 and busy=1.
  - A vector is accepted when vec_valid & vec_ready.
  - Expected value = latched gate function of (vec_a, vec_b).
  - Match: pass_cnt+1. Mismatch: fail_cnt+1.
  - If a mismatch occurs while first_fail_vld=0: first_fail_idx=accept counter, first_fail_vld=1.
  - Reserved gate_sel: every accepted vector counts as a fail.
- Latency: counters and first_fail registers update on the clock edge that accepts the vector, visible the next cycle.
- Run completion:
  - The edge accepting vector num_vecs-1 moves the FSM to DONE.
  - vec_ready drops in the same cycle that done rises; no vector beyond num_vecs is ever accepted.
- Stalls: vec_valid=0 in RUN means no update and no state change; gaps of any length are legal.
- start during RUN is ignored; latched gate_sel and num_vecs are held for the whole run.
- DONE:
  - done=1 and all results held until the next start or reset.
  - pass registered on entry: pass = (fail_cnt_final==0) & ~reserved.
  - vec_ready=0.
- start in DONE restarts exactly as from IDLE. The DONE->RUN edge drops done, and results clear that cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap. num_vecs max is 2^CNT_W-1, so saturation is unreachable by design but still required.
- Inputs are 2-state; X/Z detection is out of scope for this block.

Test Plan:
- OR, exhaustive: start, gate_sel=0, num_vecs=4, vectors (0,0,0)(0,1,1)(1,0,1)(1,1,1) back-to-back -> done=1 one cycle after 4th accept; pass=1; pass_cnt=4; fail_cnt=0; first_fail_vld=0.
- Injected fault: gate_sel=1 (AND), num_vecs=4, vectors (0,0,0)(0,1,1)(1,0,0)(1,1,0) -> fail_cnt=2, pass_cnt=2, first_fail_idx=1, first_fail_vld=1, pass=0.
- Stalls: gate_sel=2 (XOR), num_vecs=3, vec_valid toggled 1,0,0,1,0,1 with correct vectors -> accepts only on valid cycles; busy=1 throughout; done after 3rd accept; pass_cnt=3; extra valid after done is not accepted (vec_ready=0).
- Edge runs:
  - num_vecs=0 with gate_sel=4 -> RUN is skipped; done=1 on the cycle after start; pass=1; counters 0.
  - gate_sel=6, num_vecs=2 -> fail_cnt=2, pass=0.
- Reset and restart:
  - Assert rst_n=0 after 2 of 4 vectors (async, mid-cycle) -> all outputs 0 immediately; IDLE; no done.
  - start in RUN is ignored.
  - start in DONE clears counters and begins a fresh run of num_vecs=2 -> pass_cnt=2.
